// File: rtl/ledr_expect_sink.sv
`timescale 1ns/100ps
// LEDR channel sink: synchronises the d/r wires, detects tokens by phase change
// and checks each received bit against a built-in expected pattern.
module ledr_expect_sink #(
  parameter int          SYNC_STAGES = 2,
  parameter int          PAT_LEN     = 6,
  parameter logic [31:0] PATTERN     = 32'b000110,
  parameter bit          LOOP        = 1'b1,
  parameter bit          INIT_D      = 1'b0,
  parameter bit          INIT_R      = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        d_in,
  input  logic        r_in,
  input  logic        heed,
  output logic        tok_valid,
  output logic        tok_data,
  output logic [15:0] tok_count,
  output logic [4:0]  idx,
  output logic        err,
  output logic [7:0]  err_count,
  output logic        viol,
  output logic        done
);

  localparam logic [4:0] LAST_IDX = 5'(PAT_LEN - 1);

  typedef enum logic {CHECK, DONE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] d_sync_p0, r_sync_p0;
  logic                   ds, rs, dp, rp;
  logic                   d_chg, r_chg, tok_det, viol_det, err_det;
  logic                   exp_bit, mismatch, at_last;
  logic [4:0]             idx_nxt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Synchroniser stage: per-wire flop chains plus the previous-sample hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_sync_p0 <= {SYNC_STAGES{INIT_D}};
      r_sync_p0 <= {SYNC_STAGES{INIT_R}};
      dp        <= INIT_D;
      rp        <= INIT_R;
    end else begin
      d_sync_p0 <= {d_sync_p0[SYNC_STAGES-2:0], d_in};
      r_sync_p0 <= {r_sync_p0[SYNC_STAGES-2:0], r_in};
      dp        <= ds;
      rp        <= rs;
    end
  end

  assign ds = d_sync_p0[SYNC_STAGES-1];
  assign rs = r_sync_p0[SYNC_STAGES-1];

  // Exactly one wire changing flips the phase; both changing is a violation.
  always_comb begin
    d_chg    = ds ^ dp;
    r_chg    = rs ^ rp;
    tok_det  = d_chg ^ r_chg;
    viol_det = d_chg & r_chg;
    exp_bit  = PATTERN[idx];
    mismatch = done ? 1'b1 : (ds != exp_bit);
    err_det  = tok_det & heed & mismatch;
    at_last  = (idx == LAST_IDX);
    idx_nxt  = idx;
    if (tok_det && state_q == CHECK) begin
      if (at_last) idx_nxt = LOOP ? 5'd0 : LAST_IDX;
      else         idx_nxt = idx + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= CHECK;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CHECK:   if (tok_det && at_last && !LOOP) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = CHECK;
    endcase
  end

  always_comb begin
    done = (state_q == DONE);
  end

  // Detection stage: registered pulses, counters and index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tok_valid <= 1'b0;
      tok_data  <= 1'b0;
      tok_count <= 16'd0;
      idx       <= 5'd0;
      err       <= 1'b0;
      err_count <= 8'd0;
      viol      <= 1'b0;
    end else begin
      tok_valid <= tok_det;
      viol      <= viol_det;
      err       <= err_det;
      idx       <= idx_nxt;
      if (tok_det) begin
        tok_data  <= ds;
        tok_count <= sat_inc16(tok_count);
      end
      if (err_det) err_count <= sat_inc8(err_count);
    end
  end

endmodule

// File: tb/tb_ledr_expect_sink.sv
`timescale 1ns/100ps
// Directed bench for ledr_expect_sink: one looping and one one-shot instance,
// driven from a table of token records plus an asynchronous-reset sequence.
module tb_ledr_expect_sink;

  localparam int OP_TOK  = 0;
  localparam int OP_VIOL = 1;
  localparam int OP_RST  = 2;
  localparam int LAT     = 3;

  typedef struct {
    int op;
    int sel;
    bit data;
    bit heed;
    bit e_err;
    int e_idx;
    int e_cnt;
    int e_ecnt;
    bit e_done;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        heed = 1'b1;
  logic        dw[2];
  logic        rw[2];
  logic        tv[2], td[2], er[2], vi[2], dn[2];
  logic [15:0] tc[2];
  logic [4:0]  ix[2];
  logic [7:0]  ec[2];

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  ledr_expect_sink #(.LOOP(1'b1)) dut_loop (
    .clk(clk), .rst_n(rst_n), .d_in(dw[0]), .r_in(rw[0]), .heed(heed),
    .tok_valid(tv[0]), .tok_data(td[0]), .tok_count(tc[0]), .idx(ix[0]),
    .err(er[0]), .err_count(ec[0]), .viol(vi[0]), .done(dn[0])
  );

  ledr_expect_sink #(.LOOP(1'b0)) dut_once (
    .clk(clk), .rst_n(rst_n), .d_in(dw[1]), .r_in(rw[1]), .heed(heed),
    .tok_valid(tv[1]), .tok_data(td[1]), .tok_count(tc[1]), .idx(ix[1]),
    .err(er[1]), .err_count(ec[1]), .viol(vi[1]), .done(dn[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input int sel, input string tag);
    chk({tag, " tok_valid"}, 32'(tv[sel]), 0);
    chk({tag, " tok_data"},  32'(td[sel]), 0);
    chk({tag, " tok_count"}, 32'(tc[sel]), 0);
    chk({tag, " idx"},       32'(ix[sel]), 0);
    chk({tag, " err"},       32'(er[sel]), 0);
    chk({tag, " err_count"}, 32'(ec[sel]), 0);
    chk({tag, " viol"},      32'(vi[sel]), 0);
    chk({tag, " done"},      32'(dn[sel]), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      dw[s] = 1'b0;
      rw[s] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_zero(0, "rst0");
    chk_zero(1, "rst1");
  endtask

  task automatic apply(input vec_t v, input string tag);
    int lat;
    bit seen;
    if (v.op == OP_RST) begin
      do_reset();
      return;
    end
    @(negedge clk);
    heed = v.heed;
    if (v.op == OP_VIOL) begin
      dw[v.sel] = ~dw[v.sel];
      rw[v.sel] = ~rw[v.sel];
    end else if (v.data == dw[v.sel]) begin
      rw[v.sel] = ~rw[v.sel];
    end else begin
      dw[v.sel] = v.data;
    end
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (tv[v.sel] || vi[v.sel] || er[v.sel]) begin
        seen = 1'b1;
        lat  = i;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout actual=no_pulse required=pulse", tag);
      return;
    end
    chk({tag, " latency"},   32'(lat), 32'(LAT));
    chk({tag, " tok_valid"}, 32'(tv[v.sel]), 32'(v.op == OP_TOK));
    chk({tag, " viol"},      32'(vi[v.sel]), 32'(v.op == OP_VIOL));
    chk({tag, " err"},       32'(er[v.sel]), 32'(v.e_err));
    if (v.op == OP_TOK) chk({tag, " tok_data"}, 32'(td[v.sel]), 32'(v.data));
    chk({tag, " idx"},       32'(ix[v.sel]), 32'(v.e_idx));
    chk({tag, " tok_count"}, 32'(tc[v.sel]), 32'(v.e_cnt));
    chk({tag, " err_count"}, 32'(ec[v.sel]), 32'(v.e_ecnt));
    chk({tag, " done"},      32'(dn[v.sel]), 32'(v.e_done));
    @(negedge clk);
    chk({tag, " pulse_end"}, 32'({tv[v.sel], vi[v.sel], er[v.sel]}), 0);
    repeat (6) @(negedge clk);
  endtask

  function automatic void add(input int op, input int sel, input bit data, input bit hd,
                              input bit e_err, input int e_idx, input int e_cnt,
                              input int e_ecnt, input bit e_done);
    vec_t v;
    v.op = op; v.sel = sel; v.data = data; v.heed = hd; v.e_err = e_err;
    v.e_idx = e_idx; v.e_cnt = e_cnt; v.e_ecnt = e_ecnt; v.e_done = e_done;
    vecs.push_back(v);
  endfunction

  initial begin
    bit [5:0] good;
    vec_t     v;
    good = 6'b000110;
    for (int s = 0; s < 2; s++) begin
      dw[s] = 1'b0;
      rw[s] = 1'b0;
    end

    // Clean looped sequence
    add(OP_RST, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) add(OP_TOK, 0, good[i], 1, 0, (i + 1) % 6, i + 1, 0, 0);
    // Token 3 corrupted, then a double-wire violation
    add(OP_RST, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      add(OP_TOK, 0, good[i] ^ (i == 3), 1, i == 3, (i + 1) % 6, i + 1, (i >= 3) ? 1 : 0, 0);
    add(OP_VIOL, 0, 0, 1, 0, 0, 6, 1, 0);
    // Three wrong unheeded tokens, then three correct heeded ones
    add(OP_RST, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      add(OP_TOK, 0, (i < 3) ? ~good[i] : good[i], i >= 3, 0, (i + 1) % 6, i + 1, 0, 0);
    // One-shot instance: six correct tokens then an extra one
    add(OP_RST, 1, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      add(OP_TOK, 1, good[i], 1, 0, (i < 5) ? i + 1 : 5, i + 1, 0, i == 5);
    add(OP_TOK, 1, 1, 1, 1, 5, 7, 1, 1);

    for (int n = 0; n < vecs.size(); n++) apply(vecs[n], $sformatf("v%0d", n));

    // Asynchronous 1 ns reset with a partial token still inside the synchroniser
    do_reset();
    heed = 1'b1;
    for (int i = 0; i < 3; i++) begin
      v.op = OP_TOK; v.sel = 0; v.data = good[i]; v.heed = 1; v.e_err = 0;
      v.e_idx = i + 1; v.e_cnt = i + 1; v.e_ecnt = 0; v.e_done = 0;
      apply(v, $sformatf("pre%0d", i));
    end
    @(negedge clk);
    rw[0] = ~rw[0];
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    dw[0] = 1'b0;
    rw[0] = 1'b0;
    #0.5;
    chk_zero(0, "arst");
    #0.5;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("arst tok_count_after", 32'(tc[0]), 0);
    chk("arst idx_after", 32'(ix[0]), 0);
    for (int i = 0; i < 6; i++) begin
      v.op = OP_TOK; v.sel = 0; v.data = good[i]; v.heed = 1; v.e_err = 0;
      v.e_idx = (i + 1) % 6; v.e_cnt = i + 1; v.e_ecnt = 0; v.e_done = 0;
      apply(v, $sformatf("post%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ledr_expect_sink.md
# ledr_expect_sink

Clocked Verilog-side consumer for a two-wire LEDR (level-encoded dual-rail: data wire `d`, repeat wire `r`) channel driven out of prsim. It sits directly downstream of the per-wire `DELAY` stages that carry a prsim channel source into Verilog. It synchronises the asynchronous wires, detects each token by a phase change, and checks the received bit against a built-in expected sequence, either one-shot or looped. It also reports protocol violations and keeps token and error counts for the bench.

## Interface
- `SYNC_STAGES`, 2: synchroniser depth on `d_in` and `r_in`; legal values 2..4.
- `PAT_LEN`, 6: number of expected tokens; legal values 1..32.
- `PATTERN`, 32'b000110: expected bit for token `i` is `PATTERN[i]`. The default encodes the sequence 0 1 1 0 0 0.
- `LOOP`, 1: 1 makes the index wrap and check forever; 0 makes the check one-shot.
- `INIT_D`, 0 / `INIT_R`, 0: reset levels of the channel wires. Initial phase is `INIT_D ^ INIT_R`.

Ports:
- `clk` input, 1 bit: rising-edge clock.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `d_in` input, 1 bit: LEDR data wire, asynchronous.
- `r_in` input, 1 bit: LEDR repeat wire, asynchronous.
- `heed` input, 1 bit: 1 checks tokens; 0 ignores them. Ignored tokens are still tracked and counted.
- `tok_valid` output, 1 bit: one-cycle pulse per token accepted.
- `tok_data` output, 1 bit: data bit of the last token.
- `tok_count` output, 16 bits: tokens seen; saturates at 16'hFFFF.
- `idx` output, 5 bits: index of the next expected token.
- `err` output, 1 bit: one-cycle pulse when a heeded token mismatches or is an extra token.
- `err_count` output, 8 bits: saturates at 8'hFF.
- `viol` output, 1 bit: one-cycle pulse when both wires change in one sample.
- `done` output, 1 bit: asserted when `LOOP`=0 and `PAT_LEN` tokens have been consumed.

## Operation
- Each wire passes through its own `SYNC_STAGES` flop chain. The synchronised values are `ds` and `rs`. The previous sampled values are held as `dp` and `rp`.
- Phase is `ph = ds ^ rs`. A token is detected when `ph != (dp ^ rp)` and exactly one wire changed. The token's data is `ds`.
- Violation: both `ds != dp` and `rs != rp` in the same cycle.
  - Pulse `viol`.
  - Update `dp`/`rp`.
  - No token, no index advance, `err` unchanged.
- On each token:
  - `tok_valid`=1 and `tok_data`=`ds`.
  - `tok_count` increments (saturating).
  - If `heed`=1 and `done`=0: compare `ds` with `PATTERN[idx]`. On mismatch, pulse `err` and increment `err_count`.
  - If `heed`=1 and `done`=1: the token is extra. Pulse `err` and increment `err_count`.
  - If `heed`=0: no comparison and no `err`.
  - The index advances whether or not the token is heeded.
- Index update: `idx` increments per token. At `PAT_LEN-1`:
  - If `LOOP`=1, wrap to 0.
  - If `LOOP`=0, hold at `PAT_LEN-1` and set `done`, which stays sticky until reset.
- The FSM state is implied by `done`: CHECK, then either back to CHECK (wrap) or to DONE. DONE is terminal and exits only on reset.
- Reset state:
  - Sync chains, `dp` and `rp` load `INIT_D`/`INIT_R`.
  - All outputs are 0: `tok_valid`, `tok_data`, `tok_count`, `idx`, `err`, `err_count`, `viol`, `done`.
- Reset asserted mid-token: the partial token is discarded. If the wires differ from `INIT_*` after release, that difference is detected as a token (or a violation) once it has propagated through the synchronisers.

## Timing
- Latency: a wire change set up before rising edge E produces `tok_valid`/`err`/`viol` high for the cycle after edge E+`SYNC_STAGES`. That is `SYNC_STAGES`+1 edges in total.
- Pulses last exactly one cycle. Counters, `idx` and `done` update on the same edge as the pulse.
- The throughput limit is one token per cycle. Tokens closer together than one clock period are undefined and will normally appear as `viol` or a lost token. The bench must keep the token period at 2 or more clocks.
- `heed` is sampled on the detection edge. A change of `heed` takes effect for tokens detected on the following edge.

## Test plan
- Reset with `INIT_D`=`INIT_R`=0, then drive the token sequence 0,1,1,0,0,0 (toggle `r` for a repeated bit, toggle `d` for a changed bit) at 10-clock spacing. Required: 6 `tok_valid` pulses, `tok_data` sequence 0 1 1 0 0 0, `err_count`=0, `idx` returns to 0 (`LOOP`=1), `tok_count`=6.
- Drive the same sequence but with token 3 data=1. Required: exactly one `err` pulse, on token 3; `err_count`=1; `idx` keeps advancing.
- With `LOOP`=0, send 7 correct-then-extra tokens. Required: `done` rises with token 6's pulse; token 7 gives `err`; `err_count`=1; `idx` holds at 5.
- Toggle `d_in` and `r_in` simultaneously. Required: one `viol` pulse; `tok_count` and `idx` unchanged; no `err`.
- Hold `heed`=0 for the first 3 tokens, all wrong, then `heed`=1 for 3 correct tokens. Required: `err_count`=0, `tok_count`=6, `idx`=0.
- Assert `rst_n` low for 1 ns, mid-sequence and asynchronously to `clk`. Required: all outputs read 0 immediately; the next correct 6-token sequence checks clean from `idx`=0.
